mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit, 16:1 result mux (the 4-bit-select bus mux) among 16 requesters.
- Picks one requester and drives the mux select and a one-hot grant.
- Presents the selected word to a single consumer through a valid/ready handshake.
- Sits between the requesting units (e.g. debug/display sources, pipeline-stage taps) and the shared mux; the mux itself stays external.

Parameters:
- NUM_REQ, 16, number of requesters; fixed at 16 to match the 4-bit mux select.
- SEL_W, 4, select width, log2(NUM_REQ).
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  16  per-requester request; bit i drives mux input Ii.
- lock  in  16  per-requester bus-lock hint; used only with ARB_LOCK_EN.
- out_ready  in  1  consumer accepts the current word.
- sel  out  4  select to the external 16:1 mux.
- grant  out  16  one-hot owner, equal to 1<<sel while out_valid, else 0.
- out_valid  out  1  mux output is valid for the consumer.
- done  out  16  one-cycle one-hot pulse: owner's word was accepted.
- xfer_cnt  out  CNT_W  count of accepted transfers.

Behaviour:
- Reset, asynchronous, any time including mid-transfer:
  - sel=0, grant=0, out_valid=0, done=0, xfer_cnt=0.
  - last_grant=15, so index 0 has first priority.
  - State goes to IDLE.
- Two states, IDLE and BUSY. All outputs are registered.
- IDLE:
  - If req!=0, pick the first set bit scanning last_grant+1, +2, … mod 16.
  - Register sel=pick, grant=1<<pick, out_valid=1, then go to BUSY.
  - If req==0, stay in IDLE with out_valid=0 and grant=0.
  - Latency: req seen at edge k gives out_valid=1 after edge k.
- BUSY:
  - sel and grant are held stable while out_valid=1 and out_ready=0. A requester deasserting req does not revoke its grant.
  - Accept is out_valid & out_ready at a rising edge. On accept:
    - done pulses bit sel for exactly the next cycle.
    - xfer_cnt increments, wrapping from 2^CNT_W-1 to 0.
    - last_grant<=sel.
    - out_valid<=0, grant<=0, state goes to IDLE.
  - Throughput: one transfer every 2 cycles minimum, because one bubble is forced between owners.
- Round robin:
  - The current owner gets lowest priority in the next arbitration.
  - Wrap-around after index 15 returns to 0.
  - Any set of continuously asserted requests is served within 16 grants.
- A single requester that is always asserting gets every grant; there is no forced idle beyond the bubble.
- out_ready while out_valid=0 is ignored.
- req changing in the same cycle as an accept has no effect on the accept. That req value is evaluated in the following IDLE cycle.
- sel keeps its last value in IDLE; consumers must qualify it with out_valid.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With the macro defined: on accept, if req[sel] & lock[sel], stay in BUSY with the same sel and grant.
  - out_valid stays 1, giving back-to-back transfers with no bubble.
  - done and xfer_cnt update per accept as normal.
  - last_grant updates only when the owner releases, i.e. the accept where lock[sel]=0 or req[sel]=0.
- Without the macro: the lock port is present but ignored; behaviour is exactly as in Behaviour.

Decomposition:
- Shared package arb_pkg holds:
  - NUM_REQ and SEL_W constants.
  - The state typedef: IDLE, BUSY.
  - The reset value of last_grant (15).
- Natural sub-module: rr_pick16.
  - Combinational rotate-priority encoder.
  - Inputs: req[15:0], last_grant[3:0]. Outputs: pick[3:0], any.
  - The arbiter core holds all state, the counter and the handshake.

Test Plan:
- Reset and single request:
  - After rst, req=16'h0010.
  - Next edge: sel=4, grant=16'h0010, out_valid=1.
  - Hold out_ready=1: done=16'h0010 for one cycle, xfer_cnt=1, out_valid=0 the next cycle.
- Fairness with all requesting:
  - req=16'hFFFF and out_ready=1 held.
  - Grant order is 0,1,…,15,0 with exactly one IDLE bubble between grants.
  - xfer_cnt=16 after the 16th accept.
- Wrap and skip:
  - last owner 14, then req=16'h8003.
  - Grants go 15 → 0 → 1.
- Backpressure:
  - Grant 7 with out_ready=0 for 5 cycles while req[7] drops and req[3] rises.
  - sel=7 and out_valid=1 hold for all 5 cycles.
  - After out_ready=1 and the bubble, sel=3.
- Reset mid-BUSY:
  - Assert rst asynchronously, between edges, while out_valid=1.
  - Outputs clear immediately.
  - After release with req=16'h0001, the grant goes to 0.
- ARB_LOCK_EN:
  - req=16'h0024, lock=16'h0004, out_ready=1.
  - Requester 2 gets 3 back-to-back accepts with no bubble while lock[2]=1.
  - Dropping lock[2] gives one more accept, then a bubble, then sel=5.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 16-requester round-robin mux arbiter.
//
// Contents:
//   NUM_REQ, SEL_W    requester count and width of the mux select
//   LAST_GRANT_RST    reset value of the round-robin pointer (index 15),
//                     which makes index 0 the first-priority requester
//   arb_state_e       arbiter FSM states (IDLE, BUSY)
//   sel_onehot()      select index to one-hot grant vector
package arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;

  localparam logic [SEL_W-1:0] LAST_GRANT_RST = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return NUM_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotate-priority encoder for 16 requesters.
//
// Scans req starting at last_grant+1 and wrapping modulo 16; the first set
// bit found is the pick. The previous owner (last_grant itself) is the very
// last candidate, which gives it the lowest priority.
//
// Ports:
//   req        in   16  request vector
//   last_grant in    4  index of the most recent owner
//   pick       out   4  selected index (0 when any=0)
//   any        out   1  at least one request is set
module rr_pick16
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_grant,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = |req;
    // Walk from the farthest offset down to the nearest one so the nearest
    // set bit after last_grant overwrites all others. Offset 16 truncates to
    // last_grant itself.
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last_grant + SEL_W'(i);
      if (req[idx]) begin
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one external 32-bit 16:1 result mux among 16
// requesters, with a valid/ready handshake toward a single consumer.
//
// Optional feature (compile-time macro ARB_LOCK_EN): an owner that keeps both
// req and lock asserted at an accept keeps the bus and streams back-to-back
// transfers with no bubble. Without the macro the lock input is ignored.
//
// Handshake: out_valid is raised with sel/grant and all three hold steady
// until out_valid & out_ready is seen at a rising edge (the accept).
// out_ready while out_valid=0 has no effect.
//
// Ports:
//   clk        in        rising-edge clock
//   rst        in        asynchronous active-high reset
//   req        in   16   per-requester request
//   lock       in   16   per-requester bus-lock hint (ARB_LOCK_EN only)
//   out_ready  in        consumer accepts the current word
//   sel        out   4   select to the external mux (held in IDLE)
//   grant      out  16   one-hot owner while out_valid, else 0
//   out_valid  out       mux output is valid for the consumer
//   done       out  16   one-cycle one-hot pulse after an accept
//   xfer_cnt   out CNT_W accepted-transfer count (wraps)
//
// The internal state_q register is the FSM state for observation.
module mux_rr_arbiter
  import arb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               out_valid,
  output logic [NUM_REQ-1:0] done,
  output logic [CNT_W-1:0]   xfer_cnt
);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               out_valid_q, out_valid_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic [SEL_W-1:0]   last_grant_q, last_grant_d;

  logic [SEL_W-1:0]   pick;
  logic               any;
  logic               accept;
  logic               keep_owner;

  rr_pick16 u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .pick       (pick),
    .any        (any)
  );

  assign accept = out_valid_q & out_ready;

`ifdef ARB_LOCK_EN
  // The owner keeps the bus only while it is still requesting and locking.
  assign keep_owner = req[sel_q] & lock[sel_q];
`else
  assign keep_owner = 1'b0;
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    grant_d      = grant_q;
    out_valid_d  = out_valid_q;
    done_d       = '0;
    xfer_cnt_d   = xfer_cnt_q;
    last_grant_d = last_grant_q;

    unique case (state_q)
      IDLE: begin
        if (any) begin
          sel_d       = pick;
          grant_d     = sel_onehot(pick);
          out_valid_d = 1'b1;
          state_d     = BUSY;
        end else begin
          // sel keeps its last value; only valid and grant are cleared.
          grant_d     = '0;
          out_valid_d = 1'b0;
        end
      end

      BUSY: begin
        if (accept) begin
          done_d     = sel_onehot(sel_q);
          xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
          if (!keep_owner) begin
            // Releasing owner becomes lowest priority; the IDLE cycle that
            // follows is the forced bubble between owners.
            last_grant_d = sel_q;
            out_valid_d  = 1'b0;
            grant_d      = '0;
            state_d      = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      grant_q      <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= '0;
      xfer_cnt_q   <= '0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      grant_q      <= grant_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      xfer_cnt_q   <= xfer_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level round-robin model. Accepted transfers
// are queued as {count, owner}; a monitor pops one per observed done pulse.
module tb_mux_rr_arbiter;

  localparam int NR = 16;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] lock;
  logic          out_ready;
  logic [3:0]    sel;
  logic [NR-1:0] grant;
  logic          out_valid;
  logic [NR-1:0] done;
  logic [CW-1:0] xfer_cnt;

  mux_rr_arbiter #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .done      (done),
    .xfer_cnt  (xfer_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected accepted transfers: {xfer count after accept, owner index}
  logic [CW+3:0] exp_q[$];

  // ---------------- reference model ----------------
  bit      m_valid;
  int      m_sel;
  int      m_last;
  int      m_cnt;

  task automatic model_reset();
    m_valid = 0;
    m_sel   = 0;
    m_last  = 15;
    m_cnt   = 0;
    exp_q.delete();
  endtask

  // One clock of the arbitration rules, given the inputs held across it.
  task automatic model_step(input logic [NR-1:0] r, input logic [NR-1:0] l,
                            input logic rdy);
    bit keep;
    if (!m_valid) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (m_last + k) % NR;
        if (r[idx]) begin
          m_sel   = idx;
          m_valid = 1;
          break;
        end
      end
    end else if (rdy) begin
      m_cnt = (m_cnt + 1) % (1 << CW);
      exp_q.push_back({CW'(m_cnt), 4'(m_sel)});
      keep = 0;
`ifdef ARB_LOCK_EN
      keep = r[m_sel] && l[m_sel];
`endif
      if (!keep) begin
        m_last  = m_sel;
        m_valid = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [NR-1:0] g;
    g = m_valid ? (NR'(1) << m_sel) : '0;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("grant", 32'(grant), 32'(g));
    check("sel", 32'(sel), 32'(m_sel));
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drive inputs, advance model, wait one edge, compare.
  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] l,
                      input logic rdy);
    req       = r;
    lock      = l;
    out_ready = rdy;
    model_step(r, l, rdy);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && done !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got %0h expected none", done);
      end else begin
        logic [CW+3:0] e;
        logic [NR-1:0] dexp;
        e    = exp_q.pop_front();
        dexp = NR'(1) << e[3:0];
        check("done", 32'(done), 32'(dexp));
        check("xfer_cnt", 32'(xfer_cnt), 32'(e[CW+3:4]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    req       = '0;
    lock      = '0;
    out_ready = 1'b0;
    rst       = 1'b0;
    model_reset();
    #1;
    do_reset();

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);

    // single request from requester 4
    step(16'h0010, '0, 1'b1);
    check("single_sel", 32'(sel), 32'd4);
    check("single_grant", 32'(grant), 32'h0010);
    step(16'h0010, '0, 1'b1);
    check("single_done", 32'(done), 32'h0010);
    check("single_cnt", 32'(xfer_cnt), 32'd1);
    check("single_idle", 32'(out_valid), 32'd0);

    // fairness: everyone requesting
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      step(16'hFFFF, '0, 1'b1);
      check("fair_order", 32'(sel), 32'(i % 16));
      step(16'hFFFF, '0, 1'b1);
      check("fair_bubble", 32'(out_valid), 32'd0);
      if (i == 15) check("fair_cnt16", 32'(xfer_cnt), 32'd16);
    end

    // wrap and skip: owner 14, then 15 -> 0 -> 1
    do_reset();
    step(16'h4000, '0, 1'b1);
    step(16'h4000, '0, 1'b1);
    step(16'h8003, '0, 1'b1);
    check("wrap_15", 32'(sel), 32'd15);
    step(16'h8003, '0, 1'b1);
    step(16'h8003, '0, 1'b1);
    check("wrap_0", 32'(sel), 32'd0);
    step(16'h8003, '0, 1'b1);
    step(16'h8003, '0, 1'b1);
    check("wrap_1", 32'(sel), 32'd1);
    step(16'h0000, '0, 1'b1);

    // backpressure on owner 7 while req moves to 3
    do_reset();
    step(16'h0080, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(16'h0008, '0, 1'b0);
      check("bp_sel", 32'(sel), 32'd7);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    step(16'h0008, '0, 1'b1);
    step(16'h0008, '0, 1'b0);
    check("bp_next", 32'(sel), 32'd3);

    // asynchronous reset while BUSY
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_cnt", 32'(xfer_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(16'h0001, '0, 1'b1);
    check("arst_regrant", 32'(grant), 32'h0001);
    step(16'h0000, '0, 1'b1);

`ifdef ARB_LOCK_EN
    do_reset();
    step(16'h0024, 16'h0004, 1'b1);
    check("lock_first", 32'(sel), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(16'h0024, 16'h0004, 1'b1);
      check("lock_b2b_valid", 32'(out_valid), 32'd1);
      check("lock_b2b_sel", 32'(sel), 32'd2);
    end
    step(16'h0024, 16'h0000, 1'b1);
    check("lock_bubble", 32'(out_valid), 32'd0);
    step(16'h0024, 16'h0000, 1'b1);
    check("lock_next", 32'(sel), 32'd5);
    step(16'h0000, 16'h0000, 1'b1);
`endif

    // random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [NR-1:0] r;
      logic [NR-1:0] l;
      r = NR'($urandom) & NR'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      l = NR'($urandom);
      step(r, l, ($urandom_range(0, 3) != 0));
    end

    // drain and confirm every expected transfer was observed
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    step('0, '0, 1'b0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
